// File: rtl/selen_trace_pkg.sv
// Shared types for the selen bus tracer: channel-id width, channel FSM states and
// the saturating drop-counter helper.
package selen_trace_pkg;

   localparam int CH_W  = 2;
   localparam int OVF_W = 16;

   typedef enum logic {TR_IDLE = 1'b0, TR_WAIT = 1'b1} tr_state_e;

   function automatic logic [OVF_W-1:0] ovf_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/selen_trace_fifo.sv
// Generic DEPTH x WIDTH val/rdy FIFO, show-ahead; output fields come straight from the
// storage flops (no combinational path from the write side), zeroed while empty.
module selen_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_val_i,
   output logic             in_rdy_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_val_o,
   input  logic             out_rdy_i,
   output logic [WIDTH-1:0] out_data_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             full, push, pop;

   assign full       = (count_q == (AW+1)'(DEPTH));
   assign out_val_o  = (count_q != '0);
   assign pop        = out_val_o && out_rdy_i;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
   assign in_rdy_o   = !full || pop;
   assign push       = in_val_i && in_rdy_o;
   assign out_data_o = out_val_o ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/selen_bus_tracer.sv
// Multi-channel req/ack bus tracer: pairs request addresses with ack data, tags channel,
// latency and timestamp, queues records to a val/rdy port; stall/protocol flags and a watchdog.
module selen_bus_tracer
   import selen_trace_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int LAT_W     = 8,
   parameter int TS_W      = 32,
   parameter int STALL_MAX = 1024,
   parameter int TIMEOUT   = 100000
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [NUM_CH-1:0]        ch_req_val,
   input  logic [NUM_CH-1:0]        ch_req_ack,
   input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_ack_rdata,
   output logic                     trc_val,
   input  logic                     trc_rdy,
   output logic [CH_W-1:0]          trc_ch,
   output logic [ADDR_W-1:0]        trc_addr,
   output logic [DATA_W-1:0]        trc_data,
   output logic [LAT_W-1:0]         trc_lat,
   output logic [TS_W-1:0]          trc_ts,
   output logic [NUM_CH*OVF_W-1:0]  ovf_cnt,
   output logic [NUM_CH-1:0]        stall_err,
   output logic [NUM_CH-1:0]        proto_err,
   input  logic                     wd_arm,
   output logic                     wd_done,
   output logic [NUM_CH-1:0]        dbg_ch_wait
);

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [LAT_W-1:0]  lat;
      logic [TS_W-1:0]   ts;
   } trc_rec_t;

   localparam int REC_W  = $bits(trc_rec_t);
   localparam int WAIT_W = $clog2(STALL_MAX + 1);
   localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   tr_state_e         state_q [NUM_CH], state_d [NUM_CH];
   logic [ADDR_W-1:0] addr_q [NUM_CH], addr_d [NUM_CH];
   logic [LAT_W-1:0]  lat_q [NUM_CH], lat_d [NUM_CH];
   logic [WAIT_W-1:0] wait_q [NUM_CH], wait_d [NUM_CH];
   trc_rec_t          hold_rec_q [NUM_CH], hold_rec_d [NUM_CH];
   logic [OVF_W-1:0]  ovf_q [NUM_CH], ovf_d [NUM_CH];
   logic [NUM_CH-1:0] stall_q, stall_d, proto_q, proto_d;
   logic [NUM_CH-1:0] hold_val_q, hold_val_d, grant;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [TS_W-1:0]   ts_q;
   logic              wd_armed_q, wd_armed_d, wd_done_q, wd_done_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic              fifo_in_rdy, push_val;
   trc_rec_t          push_rec, pop_rec;

   // Round-robin: scan from rr_q, first valid hold register wins the single FIFO slot.
   always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      push_val = 1'b0;
      push_rec = '0;
      rr_d     = rr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(rr_q) + i) % NUM_CH;
         if (fifo_in_rdy && !push_val && hold_val_q[idx]) begin
            grant[idx] = 1'b1;
            push_val   = 1'b1;
            push_rec   = hold_rec_q[idx];
            rr_d       = CH_W'((idx + 1) % NUM_CH);
         end
      end
   end

   always_comb begin
      logic              comp;
      trc_rec_t          rec;
      logic [ADDR_W-1:0] cur_addr;
      comp     = 1'b0;
      rec      = '0;
      cur_addr = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         state_d[k]    = state_q[k];
         addr_d[k]     = addr_q[k];
         lat_d[k]      = lat_q[k];
         wait_d[k]     = wait_q[k];
         stall_d[k]    = stall_q[k];
         proto_d[k]    = proto_q[k];
         hold_val_d[k] = hold_val_q[k];
         hold_rec_d[k] = hold_rec_q[k];
         ovf_d[k]      = ovf_q[k];
         comp          = 1'b0;
         cur_addr      = ch_req_addr[k*ADDR_W +: ADDR_W];
         rec.ch        = CH_W'(k);
         rec.addr      = cur_addr;
         rec.data      = ch_ack_rdata[k*DATA_W +: DATA_W];
         rec.lat       = '0;
         rec.ts        = ts_q;

         if (!ch_en[k]) begin
            state_d[k] = TR_IDLE;
         end else begin
            case (state_q[k])
               TR_IDLE: begin
                  if (ch_req_val[k] && ch_req_ack[k]) begin
                     comp = 1'b1;
                  end else if (ch_req_val[k]) begin
                     state_d[k] = TR_WAIT;
                     addr_d[k]  = cur_addr;
                     lat_d[k]   = LAT_W'(1);
                     wait_d[k]  = WAIT_W'(1);
                  end
               end
               TR_WAIT: begin
                  if (!ch_req_val[k]) begin
                     proto_d[k] = 1'b1;
                     state_d[k] = TR_IDLE;
                  end else begin
                     if (cur_addr != addr_q[k]) proto_d[k] = 1'b1;
                     if (ch_req_ack[k]) begin
                        comp       = 1'b1;
                        rec.addr   = addr_q[k];
                        rec.lat    = lat_q[k];
                        state_d[k] = TR_IDLE;
                     end else begin
                        lat_d[k] = (&lat_q[k]) ? lat_q[k] : lat_q[k] + 1'b1;
                        if (wait_q[k] != WAIT_W'(STALL_MAX)) wait_d[k] = wait_q[k] + 1'b1;
                     end
                  end
               end
               default: state_d[k] = TR_IDLE;
            endcase
         end
         if (state_d[k] == TR_WAIT && wait_d[k] == WAIT_W'(STALL_MAX)) stall_d[k] = 1'b1;

         // A full hold register that is being drained this cycle can take the new record.
         if (comp) begin
            if (hold_val_q[k] && !grant[k]) begin
               ovf_d[k] = ovf_inc(ovf_q[k]);
            end else begin
               hold_val_d[k] = 1'b1;
               hold_rec_d[k] = rec;
            end
         end else if (grant[k]) begin
            hold_val_d[k] = 1'b0;
         end
      end
   end

   // Watchdog: the first wd_arm starts the count, wd_done latches on the TIMEOUT-th cycle.
   always_comb begin
      wd_armed_d = wd_armed_q;
      wd_cnt_d   = wd_cnt_q;
      wd_done_d  = wd_done_q;
      if (TIMEOUT != 0 && !wd_done_q) begin
         if (wd_armed_q) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
         end else if (wd_arm) begin
            wd_armed_d = 1'b1;
            wd_cnt_d   = WD_W'(1);
         end
         if (wd_cnt_d == WD_W'(TIMEOUT)) wd_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k]    <= TR_IDLE;
            addr_q[k]     <= '0;
            lat_q[k]      <= '0;
            wait_q[k]     <= '0;
            hold_rec_q[k] <= '0;
            ovf_q[k]      <= '0;
         end
         stall_q    <= '0;
         proto_q    <= '0;
         hold_val_q <= '0;
         rr_q       <= '0;
         ts_q       <= '0;
         wd_armed_q <= 1'b0;
         wd_cnt_q   <= '0;
         wd_done_q  <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k]    <= state_d[k];
            addr_q[k]     <= addr_d[k];
            lat_q[k]      <= lat_d[k];
            wait_q[k]     <= wait_d[k];
            hold_rec_q[k] <= hold_rec_d[k];
            ovf_q[k]      <= ovf_d[k];
         end
         stall_q    <= stall_d;
         proto_q    <= proto_d;
         hold_val_q <= hold_val_d;
         rr_q       <= rr_d;
         ts_q       <= ts_q + 1'b1;
         wd_armed_q <= wd_armed_d;
         wd_cnt_q   <= wd_cnt_d;
         wd_done_q  <= wd_done_d;
      end
   end

   selen_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .in_val_i   (push_val),
      .in_rdy_o   (fifo_in_rdy),
      .in_data_i  (push_rec),
      .out_val_o  (trc_val),
      .out_rdy_i  (trc_rdy),
      .out_data_o (pop_rec)
   );

   assign trc_ch    = pop_rec.ch;
   assign trc_addr  = pop_rec.addr;
   assign trc_data  = pop_rec.data;
   assign trc_lat   = pop_rec.lat;
   assign trc_ts    = pop_rec.ts;
   assign stall_err = stall_q;
   assign proto_err = proto_q;
   assign wd_done   = wd_done_q;

   always_comb begin
      ovf_cnt     = '0;
      dbg_ch_wait = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ovf_cnt[k*OVF_W +: OVF_W] = ovf_q[k];
         dbg_ch_wait[k]            = (state_q[k] == TR_WAIT);
      end
   end

endmodule
